// File: rtl/col_merge_pkg.sv
// Shared constants and types for the column-merge FIFO.
// Default geometry plus the column-index type used by the merged output.
package col_merge_pkg;

  localparam int unsigned DEF_COLS  = 4;
  localparam int unsigned DEF_DW    = 2;
  localparam int unsigned DEF_DEPTH = 4;
  localparam int unsigned DEF_CW    = $clog2(DEF_COLS);

  typedef logic [DEF_CW-1:0] col_idx_t;

endpackage

// File: rtl/col_fifo.sv
// Single-column FIFO: in-order storage of DEPTH words with push/pop/flush.
// Storage is not reset; only pointers and occupancy count are.
module col_fifo
  import col_merge_pkg::*;
#(
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DW-1:0]            wdata,
  input  logic                     pop,
  output logic [DW-1:0]            rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == {(AW+1){1'b0}});
  assign push_ok_s = push & ~full & ~flush;
  assign pop_ok_s  = pop & ~empty & ~flush;
  assign rdata     = mem_q[rd_ptr_q];
  assign count     = count_q;

  // Next pointer/count; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Word storage write port.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/col_merge_fifo.sv
// Merges COLS per-column FIFOs into one registered output stream using a
// round-robin arbiter that advances only when the output register loads.
module col_merge_fifo
  import col_merge_pkg::*;
#(
  parameter int unsigned COLS  = DEF_COLS,
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                          clk,
  input  logic                          rstb,
  input  logic                          flush,
  input  logic [COLS-1:0]               ival,
  input  logic [COLS-1:0][DW-1:0]       idata,
  output logic [COLS-1:0]               irdy,
  output logic                          oval,
  output logic [DW-1:0]                 odata,
  output logic [$clog2(COLS)-1:0]       ocol,
  input  logic                          ordy,
  output logic                          busy
);

  localparam int unsigned CW   = $clog2(COLS);
  localparam int unsigned CNTW = $clog2(DEPTH) + 1;
  localparam int unsigned LC   = COLS - 1;
  localparam logic [CW-1:0] LAST_COL = LC[CW-1:0];

  logic [COLS-1:0]           full_s;
  logic [COLS-1:0]           empty_s;
  logic [COLS-1:0]           push_s;
  logic [COLS-1:0]           pop_s;
  logic [COLS-1:0][DW-1:0]   rdata_s;
  logic [COLS-1:0][CNTW-1:0] count_s;

  logic                      load_s;
  logic [CW-1:0]             grant_s;
  logic                      oval_q, oval_d;
  logic [DW-1:0]             odata_q, odata_d;
  logic [CW-1:0]             ocol_q, ocol_d;
  logic [CW-1:0]             last_grant_q, last_grant_d;

  // First non-empty column strictly after 'last', wrapping modulo COLS.
  function automatic logic [CW-1:0] rr_pick(input logic [COLS-1:0] ne,
                                            input logic [CW-1:0]   last);
    logic [CW-1:0] idx;
    logic [CW-1:0] pick;
    logic          found;
    idx   = last;
    pick  = last;
    found = 1'b0;
    for (int unsigned i = 0; i < COLS; i++) begin
      idx = (idx == LAST_COL) ? {CW{1'b0}} : idx + 1'b1;
      if (!found && ne[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  for (genvar c = 0; c < COLS; c++) begin : g_col
    col_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rstb  (rstb),
      .flush (flush),
      .push  (push_s[c]),
      .wdata (idata[c]),
      .pop   (pop_s[c]),
      .rdata (rdata_s[c]),
      .full  (full_s[c]),
      .empty (empty_s[c]),
      .count (count_s[c])
    );
  end

  // Ready reflects stored occupancy only, so a same-cycle pop never frees a slot early.
  assign irdy   = ~full_s & {COLS{~flush}};
  assign push_s = ival & irdy;
  assign busy   = oval_q | (|count_s);
  assign oval   = oval_q;
  assign odata  = odata_q;
  assign ocol   = ocol_q;

  // Arbitration and output-register next state.
  always_comb begin
    load_s       = 1'b0;
    grant_s      = rr_pick(~empty_s, last_grant_q);
    pop_s        = '0;
    oval_d       = oval_q;
    odata_d      = odata_q;
    ocol_d       = ocol_q;
    last_grant_d = last_grant_q;
    load_s = (~oval_q | ordy) & (|(~empty_s)) & ~flush;
    if (flush) begin
      oval_d       = 1'b0;
      last_grant_d = LAST_COL;
    end else if (load_s) begin
      pop_s[grant_s] = 1'b1;
      oval_d         = 1'b1;
      odata_d        = rdata_s[grant_s];
      ocol_d         = grant_s;
      last_grant_d   = grant_s;
    end else if (ordy) begin
      oval_d = 1'b0;
    end else begin
      oval_d = oval_q;
    end
  end

  // Output register and arbiter state.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      oval_q       <= 1'b0;
      odata_q      <= '0;
      ocol_q       <= '0;
      last_grant_q <= LAST_COL;
    end else begin
      oval_q       <= oval_d;
      odata_q      <= odata_d;
      ocol_q       <= ocol_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_col_merge_fifo.sv
// Self-checking bench for col_merge_fifo: directed scenarios then random traffic,
// all compared against a queue-based reference model of the merge behaviour.
module tb_col_merge_fifo;
  import col_merge_pkg::*;

  localparam int COLS  = 4;
  localparam int DW    = 2;
  localparam int DEPTH = 4;

  logic                    clk   = 1'b0;
  logic                    rstb  = 1'b0;
  logic                    flush = 1'b0;
  logic                    ordy  = 1'b0;
  logic [COLS-1:0]         ival  = '0;
  logic [COLS-1:0][DW-1:0] idata = '0;
  logic [COLS-1:0]         irdy;
  logic                    oval;
  logic [DW-1:0]           odata;
  logic [1:0]              ocol;
  logic                    busy;

  always #5 clk = ~clk;

  col_merge_fifo #(.COLS(COLS), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rstb  (rstb),
    .flush (flush),
    .ival  (ival),
    .idata (idata),
    .irdy  (irdy),
    .oval  (oval),
    .odata (odata),
    .ocol  (ocol),
    .ordy  (ordy),
    .busy  (busy)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mq [COLS][$];
  bit            m_oval;
  logic [DW-1:0] m_odata;
  col_idx_t      m_ocol;
  int            m_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < COLS; c++) mq[c].delete();
    m_oval  = 1'b0;
    m_odata = '0;
    m_ocol  = '0;
    m_last  = COLS - 1;
  endtask

  task automatic check_all(input string tag);
    logic [COLS-1:0] e_irdy;
    bit              e_busy;
    e_busy = m_oval;
    for (int c = 0; c < COLS; c++) begin
      e_irdy[c] = (mq[c].size() < DEPTH) && !flush;
      if (mq[c].size() > 0) e_busy = 1'b1;
    end
    chk({tag, "_oval"},  {31'd0, oval}, {31'd0, m_oval});
    chk({tag, "_odata"}, {30'd0, odata}, {30'd0, m_odata});
    chk({tag, "_ocol"},  {30'd0, ocol}, {30'd0, m_ocol});
    chk({tag, "_irdy"},  {28'd0, irdy}, {28'd0, e_irdy});
    chk({tag, "_busy"},  {31'd0, busy}, {31'd0, e_busy});
  endtask

  // Apply one clock edge to the reference model using the current inputs.
  task automatic model_edge();
    bit acc [COLS];
    int sel;
    if (flush) begin
      for (int c = 0; c < COLS; c++) mq[c].delete();
      m_oval = 1'b0;
      m_last = COLS - 1;
      return;
    end
    for (int c = 0; c < COLS; c++) acc[c] = ival[c] && (mq[c].size() < DEPTH);
    sel = -1;
    for (int k = 1; k <= COLS; k++) begin
      int c;
      c = (m_last + k) % COLS;
      if (sel < 0 && mq[c].size() > 0) sel = c;
    end
    if ((!m_oval || ordy) && sel >= 0) begin
      m_odata = mq[sel].pop_front();
      m_ocol  = col_idx_t'(sel);
      m_oval  = 1'b1;
      m_last  = sel;
    end else if (ordy) begin
      m_oval = 1'b0;
    end
    for (int c = 0; c < COLS; c++) if (acc[c]) mq[c].push_back(idata[c]);
  endtask

  task automatic cycle(input string tag);
    #1;
    check_all(tag);
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstb  = 1'b0;
    ival  = '0;
    flush = 1'b0;
    ordy  = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    rstb = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    #1;
    chk("rst_oval",  {31'd0, oval}, 32'd0);
    chk("rst_odata", {30'd0, odata}, 32'd0);
    chk("rst_ocol",  {30'd0, ocol}, 32'd0);
    chk("rst_irdy",  {28'd0, irdy}, 32'hf);
    chk("rst_busy",  {31'd0, busy}, 32'd0);

    // Single word on column 2: visible two cycles later, then idle.
    ordy     = 1'b1;
    ival     = 4'b0100;
    idata[2] = 2'b11;
    cycle("single");
    ival = '0;
    cycle("single");
    #1;
    chk("lat_oval",  {31'd0, oval}, 32'd1);
    chk("lat_odata", {30'd0, odata}, 32'd3);
    chk("lat_ocol",  {30'd0, ocol}, 32'd2);
    cycle("single");
    #1;
    chk("lat_busy", {31'd0, busy}, 32'd0);

    // All columns push at once: round-robin from column 0.
    do_reset();
    ordy  = 1'b1;
    ival  = 4'hf;
    idata = 8'b11_10_01_00;
    cycle("allcol");
    ival = '0;
    cycle("allcol");
    for (int k = 0; k < COLS; k++) begin
      #1;
      chk("rr_oval", {31'd0, oval}, 32'd1);
      chk("rr_ocol", {30'd0, ocol}, k);
      cycle("allcol");
    end

    // Back-pressure on column 1: five accepted, sixth refused, order kept.
    do_reset();
    ordy = 1'b0;
    ival = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      idata[1] = 2'(i);
      cycle("bp");
    end
    #1;
    chk("bp_irdy1_low", {31'd0, irdy[1]}, 32'd0);
    idata[1] = 2'b01;
    cycle("bp");
    ival = '0;
    repeat (3) cycle("hold");
    #1;
    chk("hold_odata", {30'd0, odata}, 32'd0);
    chk("hold_ocol",  {30'd0, ocol}, 32'd1);
    ordy = 1'b1;
    repeat (7) cycle("drain");

    // Flush with everything full.
    do_reset();
    ordy = 1'b0;
    ival = 4'hf;
    for (int i = 0; i < 6; i++) begin
      idata = 8'($urandom);
      cycle("fill");
    end
    ival  = '0;
    flush = 1'b1;
    cycle("flush");
    flush = 1'b0;
    #1;
    chk("flush_oval", {31'd0, oval}, 32'd0);
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_irdy", {28'd0, irdy}, 32'hf);
    ordy     = 1'b1;
    ival     = 4'b1000;
    idata[3] = 2'b10;
    cycle("post_flush");
    ival = '0;
    cycle("post_flush");
    #1;
    chk("pf_oval",  {31'd0, oval}, 32'd1);
    chk("pf_odata", {30'd0, odata}, 32'd2);
    chk("pf_ocol",  {30'd0, ocol}, 32'd3);
    cycle("post_flush");

    // Asynchronous reset with words buffered and the output loaded.
    ordy = 1'b0;
    ival = 4'hf;
    repeat (3) cycle("pre_rst");
    ival = '0;
    #2;
    rstb = 1'b0;
    #1;
    chk("arst_oval",  {31'd0, oval}, 32'd0);
    chk("arst_odata", {30'd0, odata}, 32'd0);
    chk("arst_ocol",  {30'd0, ocol}, 32'd0);
    chk("arst_busy",  {31'd0, busy}, 32'd0);
    chk("arst_irdy",  {28'd0, irdy}, 32'hf);
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rstb = 1'b1;
    ordy = 1'b1;
    repeat (4) cycle("post_rst");

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      ival  = 4'($urandom);
      idata = 8'($urandom);
      ordy  = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 59) == 0);
      cycle("rand");
    end
    ival  = '0;
    flush = 1'b0;
    ordy  = 1'b1;
    repeat (20) cycle("rand_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/col_merge_fifo.md
COL_MERGE_FIFO -- requirements
Module: col_merge_fifo

Interface
REQ-001 Parameter COLS, default 4, number of input columns (2..16).
REQ-002 Parameter DW, default 2, data bits per column word (>=1).
REQ-003 Parameter DEPTH, default 4, per-column FIFO entries (power of 2, >=2).
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rstb  in  1  reset, asynchronous assert, active-low.
REQ-006 flush  in  1  synchronous clear of all buffered data.
REQ-007 ival  in  COLS  per-column input valid.
REQ-008 idata  in  [COLS-1:0][DW-1:0]  per-column input word.
REQ-009 irdy  out  COLS  per-column input ready.
REQ-010 oval  out  1  merged output valid (registered).
REQ-011 odata  out  DW  merged output word (registered).
REQ-012 ocol  out  $clog2(COLS)  source column of odata (registered).
REQ-013 ordy  in  1  downstream ready.
REQ-014 busy  out  1  any FIFO non-empty or oval high.

Function
REQ-015 Column c input transfer occurs when ival[c] & irdy[c] at a rising edge.
REQ-016 irdy[c] = !full[c] & !flush; full[c] depends on stored count only, never on same-cycle pops.
REQ-017 Each column FIFO holds DEPTH words, in order; count range 0..DEPTH, pointers wrap modulo DEPTH.
REQ-018 Push and pop on same column same cycle: count unchanged, both pointers advance.
REQ-019 Output register loads when (!oval | ordy) and at least one FIFO non-empty; loading pops exactly one word.
REQ-020 Output transfer occurs when oval & ordy; if no load that cycle, oval clears next cycle.
REQ-021 Arbitration round-robin: search starts at column last_grant+1 mod COLS, first non-empty column wins; last_grant updates only on a load.
REQ-022 Latency: word pushed into empty FIFO in cycle N with output register free appears on oval in cycle N+2.
REQ-023 Throughput: with ordy=1 continuously and data available, one word per cycle on oval.
REQ-024 oval held with odata/ocol stable while ordy=0.
REQ-025 flush=1: next cycle all counts 0, pointers 0, oval 0, last_grant = COLS-1; pushes and loads in flush cycle suppressed.
REQ-026 busy is combinational OR of all non-empty flags and oval.

Reset
REQ-027 rstb low: oval=0, odata=0, ocol=0, all counts and pointers 0, last_grant=COLS-1 (column 0 first priority); irdy all 1, busy 0 after reset.
REQ-028 Reset mid-operation discards all buffered and in-flight words without any output transfer.
REQ-029 FIFO storage arrays need no reset; only control state and output registers reset.

Structure
REQ-030 Shared package col_merge_pkg holds default COLS/DW/DEPTH constants and the column-index typedef.
REQ-031 One sub-module col_fifo (single-column FIFO: push/pop/flush, full/empty, count) instantiated COLS times via generate.
REQ-032 Arbiter and output register live in the top module; no other hierarchy.

Verification (COLS=4, DW=2, DEPTH=4)
REQ-033 Reset, then single push col2 data 2'b11 at cycle 0, ordy=1 -> oval=1, odata=3, ocol=2 at cycle 2; busy 0 at cycle 3.
REQ-034 All columns push one word same cycle, ordy=1 -> outputs ocol 0,1,2,3 on four consecutive cycles.
REQ-035 ordy=0, push col1 five times back-to-back -> irdy[1] low after 5th accepted (4 FIFO + 1 output reg); 6th word not accepted; order preserved on release.
REQ-036 ordy=0 with oval high for 3 cycles -> odata/ocol unchanged; ordy=1 -> next word following cycle.
REQ-037 Full FIFOs plus oval, flush pulse -> next cycle oval=0, busy=0, irdy=4'b1111; subsequent push reappears with normal latency.
REQ-038 rstb asserted with words buffered -> outputs at reset values asynchronously; no stale word after release.
